// File: rtl/fpu_adder.sv
`default_nettype none
// ============================================================================
// Module   : fpu_adder
// Purpose  : Pipelined IEEE-754 single-precision adder, data_out = A + B.
//            Denormal operands are flushed to signed zero. Results are
//            rounded to nearest, ties to even. One result per cycle, with a
//            fixed three-cycle latency from operand sample to output.
// Ports    : clock_100Khz      system clock, rising-edge active
//            reset             synchronous active-high reset
//            Op_A_in[31:0]     operand A
//            Op_B_in[31:0]     operand B
//            data_out[31:0]    registered sum
//            status_out[3:0]   registered one-hot status
//                              0001 EXACT, 0010 OVERFLOW,
//                              0100 UNDERFLOW, 1000 INEXACT
// Revision : 1.0  initial release
// ============================================================================
module fpu_adder (
    input  logic        clock_100Khz,
    input  logic        reset,
    input  logic [31:0] Op_A_in,
    input  logic [31:0] Op_B_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    localparam logic [3:0]  ST_EXACT     = 4'b0001;
    localparam logic [3:0]  ST_OVERFLOW  = 4'b0010;
    localparam logic [3:0]  ST_UNDERFLOW = 4'b0100;
    localparam logic [3:0]  ST_INEXACT   = 4'b1000;
    localparam logic [31:0] QNAN         = 32'h7FC0_0000;
    // From this exponent difference on, the whole smaller significand
    // falls below the round bit and only contributes to sticky.
    localparam logic [7:0]  ALIGN_LIMIT  = 8'd26;

    // ------------------------------------------------------------------
    // Operand registers
    // ------------------------------------------------------------------
    logic        in_vld_q, in_vld_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;

    // ------------------------------------------------------------------
    // Stage 1 registers: unpacked, L = larger magnitude, S = smaller
    // ------------------------------------------------------------------
    logic        s1_vld_q, s1_vld_d;
    logic        s1_sign_q, s1_sign_d;
    logic        s1_sub_q, s1_sub_d;
    logic        s1_zsign_q, s1_zsign_d;
    logic [7:0]  s1_exp_l_q, s1_exp_l_d;
    logic [7:0]  s1_exp_s_q, s1_exp_s_d;
    logic [23:0] s1_sig_l_q, s1_sig_l_d;
    logic [23:0] s1_sig_s_q, s1_sig_s_d;
    logic        s1_spec_q, s1_spec_d;
    logic [31:0] s1_spec_data_q, s1_spec_data_d;

    // ------------------------------------------------------------------
    // Stage 2 registers: aligned sum {carry, hidden, frac[22:0], g, r, s}
    // ------------------------------------------------------------------
    logic        s2_vld_q, s2_vld_d;
    logic        s2_sign_q, s2_sign_d;
    logic        s2_zsign_q, s2_zsign_d;
    logic [7:0]  s2_exp_q, s2_exp_d;
    logic [27:0] s2_sum_q, s2_sum_d;
    logic        s2_spec_q, s2_spec_d;
    logic [31:0] s2_spec_data_q, s2_spec_data_d;

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [31:0] data_out_q, data_out_d;
    logic [3:0]  status_out_q, status_out_d;

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    always_comb begin
        in_vld_d = 1'b1;
        op_a_d   = Op_A_in;
        op_b_d   = Op_B_in;
    end

    // ------------------------------------------------------------------
    // Stage 1: classify, restore hidden bit, order by magnitude
    // ------------------------------------------------------------------
    logic        w_a_zero, w_b_zero;
    logic        w_a_inf, w_b_inf;
    logic        w_a_nan, w_b_nan;
    logic        w_a_ge;
    logic [23:0] w_a_sig, w_b_sig;
    logic [30:0] w_a_key, w_b_key;

    always_comb begin
        w_a_zero = (op_a_q[30:23] == 8'h00);
        w_b_zero = (op_b_q[30:23] == 8'h00);
        w_a_inf  = (op_a_q[30:23] == 8'hFF) && (op_a_q[22:0] == 23'd0);
        w_b_inf  = (op_b_q[30:23] == 8'hFF) && (op_b_q[22:0] == 23'd0);
        w_a_nan  = (op_a_q[30:23] == 8'hFF) && (op_a_q[22:0] != 23'd0);
        w_b_nan  = (op_b_q[30:23] == 8'hFF) && (op_b_q[22:0] != 23'd0);
        w_a_sig  = w_a_zero ? 24'd0 : {1'b1, op_a_q[22:0]};
        w_b_sig  = w_b_zero ? 24'd0 : {1'b1, op_b_q[22:0]};
        // Exponent:fraction orders magnitudes; denormals compare as zero.
        w_a_key  = w_a_zero ? 31'd0 : op_a_q[30:0];
        w_b_key  = w_b_zero ? 31'd0 : op_b_q[30:0];
        w_a_ge   = (w_a_key >= w_b_key);

        s1_vld_d   = in_vld_q;
        s1_sub_d   = op_a_q[31] ^ op_b_q[31];
        // Sign used whenever the magnitude ends up exactly zero.
        s1_zsign_d = op_a_q[31] & op_b_q[31];

        if (w_a_ge) begin
            s1_sign_d  = op_a_q[31];
            s1_exp_l_d = op_a_q[30:23];
            s1_exp_s_d = op_b_q[30:23];
            s1_sig_l_d = w_a_sig;
            s1_sig_s_d = w_b_sig;
        end else begin
            s1_sign_d  = op_b_q[31];
            s1_exp_l_d = op_b_q[30:23];
            s1_exp_s_d = op_a_q[30:23];
            s1_sig_l_d = w_b_sig;
            s1_sig_s_d = w_a_sig;
        end

        s1_spec_d = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (op_a_q[31] != op_b_q[31]))) begin
            s1_spec_data_d = QNAN;
        end else if (w_a_inf) begin
            s1_spec_data_d = {op_a_q[31], 8'hFF, 23'd0};
        end else begin
            s1_spec_data_d = {op_b_q[31], 8'hFF, 23'd0};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: align S to L and add or subtract
    // ------------------------------------------------------------------
    logic [7:0]  w_diff;
    logic [49:0] w_shifted;
    logic [26:0] w_s_ext;
    logic [26:0] w_l_ext;

    always_comb begin
        w_diff    = s1_exp_l_q - s1_exp_s_q;
        // 26 zero bits below S catch everything shifted out for diff < 26.
        w_shifted = {s1_sig_s_q, 26'd0} >> w_diff;
        if (w_diff >= ALIGN_LIMIT) begin
            w_s_ext = {26'd0, |s1_sig_s_q};
        end else begin
            w_s_ext = {w_shifted[49:24], |w_shifted[23:0]};
        end
        w_l_ext = {s1_sig_l_q, 3'b000};

        // L >= aligned S, so the subtraction never goes negative.
        if (s1_sub_q) begin
            s2_sum_d = {1'b0, w_l_ext} - {1'b0, w_s_ext};
        end else begin
            s2_sum_d = {1'b0, w_l_ext} + {1'b0, w_s_ext};
        end

        s2_vld_d       = s1_vld_q;
        s2_sign_d      = s1_sign_q;
        s2_zsign_d     = s1_zsign_q;
        s2_exp_d       = s1_exp_l_q;
        s2_spec_d      = s1_spec_q;
        s2_spec_data_d = s1_spec_data_q;
    end

    // ------------------------------------------------------------------
    // Stage 3: normalize, round, classify, pack
    // ------------------------------------------------------------------
    logic [4:0]  w_lzc;
    logic [26:0] w_norm;
    logic [9:0]  w_exp_n;
    logic [9:0]  w_exp_f;
    logic [24:0] w_rnd;
    logic        w_round_up;
    logic        w_inexact;
    logic [22:0] w_frac;

    always_comb begin
        w_lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (s2_sum_q[i]) begin
                w_lzc = 5'(26 - i);
            end
        end

        if (s2_sum_q[27]) begin
            // Carry out: shift right one, folding the lost bit into sticky.
            w_norm  = {s2_sum_q[27:2], s2_sum_q[1] | s2_sum_q[0]};
            w_exp_n = {2'b00, s2_exp_q} + 10'd1;
        end else begin
            w_norm  = s2_sum_q[26:0] << w_lzc;
            w_exp_n = {2'b00, s2_exp_q} - {5'd0, w_lzc};
        end

        w_inexact  = |w_norm[2:0];
        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd      = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
        // Rounding 1.111..1 up gives 10.000..0: renormalize by one.
        w_exp_f    = w_exp_n + {9'd0, w_rnd[24]};
        w_frac     = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];

        data_out_d   = data_out_q;
        status_out_d = status_out_q;
        if (s2_vld_q) begin
            if (s2_spec_q) begin
                data_out_d   = s2_spec_data_q;
                status_out_d = ST_OVERFLOW;
            end else if (s2_sum_q == 28'd0) begin
                data_out_d   = {s2_zsign_q, 31'd0};
                status_out_d = ST_EXACT;
            end else if ($signed(w_exp_f) >= 10'sd255) begin
                data_out_d   = {s2_sign_q, 8'hFF, 23'd0};
                status_out_d = ST_OVERFLOW;
            end else if ($signed(w_exp_f) <= 10'sd0) begin
                data_out_d   = {s2_sign_q, 31'd0};
                status_out_d = ST_UNDERFLOW;
            end else begin
                data_out_d   = {s2_sign_q, w_exp_f[7:0], w_frac};
                status_out_d = w_inexact ? ST_INEXACT : ST_EXACT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            in_vld_q       <= 1'b0;
            op_a_q         <= 32'd0;
            op_b_q         <= 32'd0;
            s1_vld_q       <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_sub_q       <= 1'b0;
            s1_zsign_q     <= 1'b0;
            s1_exp_l_q     <= 8'd0;
            s1_exp_s_q     <= 8'd0;
            s1_sig_l_q     <= 24'd0;
            s1_sig_s_q     <= 24'd0;
            s1_spec_q      <= 1'b0;
            s1_spec_data_q <= 32'd0;
            s2_vld_q       <= 1'b0;
            s2_sign_q      <= 1'b0;
            s2_zsign_q     <= 1'b0;
            s2_exp_q       <= 8'd0;
            s2_sum_q       <= 28'd0;
            s2_spec_q      <= 1'b0;
            s2_spec_data_q <= 32'd0;
            data_out_q     <= 32'd0;
            status_out_q   <= 4'd0;
        end else begin
            in_vld_q       <= in_vld_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            s1_vld_q       <= s1_vld_d;
            s1_sign_q      <= s1_sign_d;
            s1_sub_q       <= s1_sub_d;
            s1_zsign_q     <= s1_zsign_d;
            s1_exp_l_q     <= s1_exp_l_d;
            s1_exp_s_q     <= s1_exp_s_d;
            s1_sig_l_q     <= s1_sig_l_d;
            s1_sig_s_q     <= s1_sig_s_d;
            s1_spec_q      <= s1_spec_d;
            s1_spec_data_q <= s1_spec_data_d;
            s2_vld_q       <= s2_vld_d;
            s2_sign_q      <= s2_sign_d;
            s2_zsign_q     <= s2_zsign_d;
            s2_exp_q       <= s2_exp_d;
            s2_sum_q       <= s2_sum_d;
            s2_spec_q      <= s2_spec_d;
            s2_spec_data_q <= s2_spec_data_d;
            data_out_q     <= data_out_d;
            status_out_q   <= status_out_d;
        end
    end

    assign data_out   = data_out_q;
    assign status_out = status_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_adder
// Purpose  : Self-checking bench for fpu_adder. An exact wide-integer model
//            of the sum, followed by round-to-nearest-even and range checks,
//            predicts every output; directed vectors also carry hand-computed
//            literal results.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_fpu_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int passed = 0;
    int total  = 0;

    fpu_adder dut (
        .clock_100Khz (clk),
        .reset        (rst),
        .Op_A_in      (op_a),
        .Op_B_in      (op_b),
        .data_out     (data_out),
        .status_out   (status_out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference: exact sum as a wide integer, then round and classify.
    // Returns {status, data}.
    // ------------------------------------------------------------------
    function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        int           ea, eb, base, p, e, sh;
        logic [299:0] wa, wb, mag, q, rem, half;
        logic         rs, inexact, nan_a, nan_b, inf_a, inf_b;
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 23'd0);
        nan_b = (eb == 255) && (b[22:0] != 23'd0);
        inf_a = (ea == 255) && (a[22:0] == 23'd0);
        inf_b = (eb == 255) && (b[22:0] == 23'd0);
        if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31])))
            return {4'b0010, 32'h7FC00000};
        if (inf_a) return {4'b0010, a[31], 8'hFF, 23'd0};
        if (inf_b) return {4'b0010, b[31], 8'hFF, 23'd0};
        // value = sig * 2^(e-150); zero/denormal operands are exactly 0
        wa = (ea == 0) ? 300'd0 : 300'({1'b1, a[22:0]});
        wb = (eb == 0) ? 300'd0 : 300'({1'b1, b[22:0]});
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        base = (ea < eb) ? ea : eb;
        wa = wa << (ea - base);
        wb = wb << (eb - base);
        if (a[31] == b[31]) begin
            mag = wa + wb; rs = a[31];
        end else if (wa >= wb) begin
            mag = wa - wb; rs = a[31];
        end else begin
            mag = wb - wa; rs = b[31];
        end
        if (mag == 300'd0) return {4'b0001, a[31] & b[31], 31'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = base + p - 23;
        inexact = 1'b0;
        if (p > 23) begin
            sh      = p - 23;
            q       = mag >> sh;
            rem     = mag & ((300'd1 << sh) - 300'd1);
            half    = 300'd1 << (sh - 1);
            inexact = (rem != 300'd0);
            if (rem > half || (rem == half && q[0])) q = q + 300'd1;
            if (q[24]) begin
                q = q >> 1;
                e = e + 1;
            end
        end else begin
            q = mag << (23 - p);
        end
        if (e >= 255) return {4'b0010, rs, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0100, rs, 31'd0};
        return {inexact ? 4'b1000 : 4'b0001, rs, 8'(e), q[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] gd, input logic [3:0] gs,
                         input logic [31:0] wd, input logic [3:0] ws);
        total++;
        if (gd === wd && gs === ws) passed++;
        else $display("FAIL %s: got data=%h status=%b, want data=%h status=%b",
                      name, gd, gs, wd, ws);
    endtask

    // ------------------------------------------------------------------
    // Latency model: result of operands sampled at edge N is due after N+3
    // ------------------------------------------------------------------
    logic        cur_lit_en = 1'b0;
    logic [31:0] cur_lit_d  = 32'd0;
    logic [3:0]  cur_lit_s  = 4'd0;
    int          cur_idx    = 0;

    logic        pv [3];
    logic [35:0] pr [3];
    logic        pl [3];
    logic [35:0] plr[3];
    int          pi [3];

    logic        started  = 1'b0;
    logic        zero_chk = 1'b0;
    logic [31:0] exp_d    = 32'd0;
    logic [3:0]  exp_s    = 4'd0;
    logic        olit_en  = 1'b0;
    logic [35:0] olit     = 36'd0;
    int          olit_idx = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] = 1'b0;
                pl[i] = 1'b0;
            end
            exp_d    = 32'd0;
            exp_s    = 4'd0;
            olit_en  = 1'b0;
            started  = 1'b1;
            zero_chk = 1'b1;
        end else begin
            zero_chk = 1'b0;
            olit_en  = pv[2] && pl[2];
            olit     = plr[2];
            olit_idx = pi[2];
            if (pv[2]) {exp_s, exp_d} = pr[2];
            for (int i = 2; i > 0; i--) begin
                pv[i]  = pv[i-1];
                pr[i]  = pr[i-1];
                pl[i]  = pl[i-1];
                plr[i] = plr[i-1];
                pi[i]  = pi[i-1];
            end
            pv[0]  = 1'b1;
            pr[0]  = ref_add(op_a, op_b);
            pl[0]  = cur_lit_en;
            plr[0] = {cur_lit_s, cur_lit_d};
            pi[0]  = cur_idx;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model", data_out, status_out, exp_d, exp_s);
            if (olit_en)
                check($sformatf("directed#%0d", olit_idx), data_out, status_out,
                      olit[31:0], olit[35:32]);
            if (zero_chk)
                check("reset_clear", data_out, status_out, 32'd0, 4'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic le,
                         input logic [31:0] ld, input logic [3:0] ls, input int idx);
        op_a = a; op_b = b;
        cur_lit_en = le; cur_lit_d = ld; cur_lit_s = ls; cur_idx = idx;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_op(input logic [31:0] other);
        logic [31:0] r;
        int          e;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r = {r[31], 8'h00, ($urandom_range(0, 1) == 0) ? 23'd0 : r[22:0]};
            1: r = {r[31], 8'hFF, ($urandom_range(0, 2) == 0) ? r[22:0] : 23'd0};
            2: r = {~other[31], other[30:0]};
            3: begin
                e = int'(other[30:23]) + int'($urandom_range(0, 4)) - 2;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                r = {r[31], 8'(e), r[22:0]};
            end
            4: r[30:23] = 8'($urandom_range(250, 254));
            5: r[30:23] = 8'($urandom_range(1, 4));
            6: r = {~other[31], other[30:3], r[2:0]};
            default: r[30:23] = 8'($urandom_range(1, 254));
        endcase
        return r;
    endfunction

    logic [31:0] da [17];
    logic [31:0] db [17];
    logic [31:0] dd [17];
    logic [3:0]  ds [17];

    initial begin
        logic [35:0] m;
        logic [31:0] ra, rb;

        da[0]  = 32'h40000000; db[0]  = 32'h40800000; dd[0]  = 32'h40C00000; ds[0]  = 4'b0001;
        da[1]  = 32'h41400000; db[1]  = 32'h40200000; dd[1]  = 32'h41680000; ds[1]  = 4'b0001;
        da[2]  = 32'h40C00000; db[2]  = 32'h00000000; dd[2]  = 32'h40C00000; ds[2]  = 4'b0001;
        da[3]  = 32'hC0800000; db[3]  = 32'h00000000; dd[3]  = 32'hC0800000; ds[3]  = 4'b0001;
        da[4]  = 32'h41800000; db[4]  = 32'hC1800000; dd[4]  = 32'h00000000; ds[4]  = 4'b0001;
        da[5]  = 32'h41700000; db[5]  = 32'hC0C00000; dd[5]  = 32'h41100000; ds[5]  = 4'b0001;
        da[6]  = 32'h46000000; db[6]  = 32'h40000000; dd[6]  = 32'h46000800; ds[6]  = 4'b0001;
        da[7]  = 32'h444D951E; db[7]  = 32'h444D951E; dd[7]  = 32'h44CD951E; ds[7]  = 4'b0001;
        da[8]  = 32'h4B800000; db[8]  = 32'h3F800000; dd[8]  = 32'h4B800000; ds[8]  = 4'b1000;
        da[9]  = 32'h4B800001; db[9]  = 32'h3F800000; dd[9]  = 32'h4B800002; ds[9]  = 4'b1000;
        da[10] = 32'h7F7FFFFF; db[10] = 32'h7F7FFFFF; dd[10] = 32'h7F800000; ds[10] = 4'b0010;
        da[11] = 32'h00800000; db[11] = 32'h80800001; dd[11] = 32'h80000000; ds[11] = 4'b0100;
        da[12] = 32'h7F800000; db[12] = 32'hFF800000; dd[12] = 32'h7FC00000; ds[12] = 4'b0010;
        da[13] = 32'h80000000; db[13] = 32'h80000000; dd[13] = 32'h80000000; ds[13] = 4'b0001;
        da[14] = 32'h80000000; db[14] = 32'h00000000; dd[14] = 32'h00000000; ds[14] = 4'b0001;
        da[15] = 32'h3F800000; db[15] = 32'hFF800000; dd[15] = 32'hFF800000; ds[15] = 4'b0010;
        da[16] = 32'h7FC00001; db[16] = 32'h3F800000; dd[16] = 32'h7FC00000; ds[16] = 4'b0010;

        // Pin the reference model against hand-derived results.
        m = ref_add(32'h4B800000, 32'h3F800000);
        check("model_pin_tie", m[31:0], m[35:32], 32'h4B800000, 4'b1000);
        m = ref_add(32'h00800000, 32'h80800001);
        check("model_pin_underflow", m[31:0], m[35:32], 32'h80000000, 4'b0100);
        m = ref_add(32'h41700000, 32'hC0C00000);
        check("model_pin_sub", m[31:0], m[35:32], 32'h41100000, 4'b0001);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) drive(da[i], db[i], 1'b1, dd[i], ds[i], i);

        for (int n = 0; n < 600; n++) begin
            ra = rnd_op($urandom);
            rb = rnd_op(ra);
            if (n == 200 || n == 400) begin
                rst = 1'b1;
                drive(ra, rb, 1'b0, 32'd0, 4'd0, 0);
                if (n == 400) drive(rb, ra, 1'b0, 32'd0, 4'd0, 0);
                rst = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                drive(ra, rb, 1'b0, 32'd0, 4'd0, 0);
            end else begin
                drive(rb, ra, 1'b0, 32'd0, 4'd0, 0);
            end
        end

        for (int i = 0; i < 5; i++) drive(32'd0, 32'd0, 1'b0, 32'd0, 4'd0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
